// File: rtl/async_arb_pkg.sv
// Shared types and constants for the per-core async arbiter client.
package async_arb_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t REQ     = 2'd1;
  localparam state_t GRANTED = 2'd2;
  localparam state_t RELEASE = 2'd3;

endpackage

// File: rtl/async_arb_sync.sv
// N-flop single-bit synchronizer, asynchronous active-high reset.
module async_arb_sync #(
  parameter int STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_arb_client.sv
// Core-side front end turning acquire/release pulses into a 4-phase req/ack
// handshake on one arbiter leaf. Optional wait statistics: ASYNC_ARB_CLIENT_STATS_EN.
module async_arb_client
  import async_arb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_W      = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              acquire_i,
  input  logic              release_i,
  output logic              granted_o,
  output logic              busy_o,
  output logic              arb_req_o,
  input  logic              arb_ack_i
`ifdef ASYNC_ARB_CLIENT_STATS_EN
  ,
  output logic [WAIT_W-1:0] wait_last_o,
  output logic [WAIT_W-1:0] wait_max_o
`endif
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("async_arb_client: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end
  if (WAIT_W < 1) begin : g_bad_wait
    $error("async_arb_client: WAIT_W must be >= 1");
  end

  logic   ack_s;
  state_t state_q, state_d;
  logic   acq_pend_q, acq_pend_d;
  logic   rel_pend_q, rel_pend_d;
  logic   arb_req_q, granted_q, busy_q;

  async_arb_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (arb_ack_i),
    .q_o     (ack_s)
  );

  always_comb begin
    state_d    = state_q;
    acq_pend_d = acq_pend_q;
    rel_pend_d = rel_pend_q;
    case (state_q)
      IDLE: begin
        acq_pend_d = 1'b0;
        if (acquire_i || acq_pend_q) state_d = REQ;
      end
      REQ: begin
        if (release_i) rel_pend_d = 1'b1;
        // A release landing in the same cycle as ack_s still counts as an abort.
        if (ack_s) begin
          rel_pend_d = 1'b0;
          state_d    = (rel_pend_q || release_i) ? RELEASE : GRANTED;
        end
      end
      GRANTED: begin
        if (release_i) begin
          state_d = RELEASE;
          if (acquire_i) acq_pend_d = 1'b1;
        end
      end
      RELEASE: begin
        if (acquire_i) acq_pend_d = 1'b1;
        if (!ack_s)    state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      acq_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      arb_req_q  <= 1'b0;
      granted_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acq_pend_q <= acq_pend_d;
      rel_pend_q <= rel_pend_d;
      arb_req_q  <= (state_d == REQ) || (state_d == GRANTED);
      granted_q  <= (state_d == GRANTED);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign arb_req_o = arb_req_q;
  assign granted_o = granted_q;
  assign busy_o    = busy_q;

`ifdef ASYNC_ARB_CLIENT_STATS_EN
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, cnt_inc;
  logic [WAIT_W-1:0] wait_last_q, wait_last_d, wait_max_q, wait_max_d;

  // cnt_inc counts the current REQ cycle too, so at grant it equals cycles spent in REQ.
  always_comb begin
    cnt_inc     = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    wait_cnt_d  = wait_cnt_q;
    wait_last_d = wait_last_q;
    wait_max_d  = wait_max_q;
    if (state_q != REQ && state_d == REQ) wait_cnt_d = '0;
    else if (state_q == REQ)              wait_cnt_d = cnt_inc;
    if (state_q == REQ && state_d == GRANTED) begin
      wait_last_d = cnt_inc;
      if (cnt_inc > wait_max_q) wait_max_d = cnt_inc;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_q  <= '0;
      wait_last_q <= '0;
      wait_max_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      wait_last_q <= wait_last_d;
      wait_max_q  <= wait_max_d;
    end
  end

  assign wait_last_o = wait_last_q;
  assign wait_max_o  = wait_max_q;
`endif

endmodule

// File: tb/tb_async_arb_client.sv
// Scoreboard bench for async_arb_client: expected output edges (and wait stats)
// are queued as stimulus is scripted and matched as the monitor sees them.
module tb_async_arb_client;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic acq = 1'b0, rel = 1'b0, ack = 1'b0;
  logic req, gnt, busy;
`ifdef ASYNC_ARB_CLIENT_STATS_EN
  logic [15:0] wl, wm;
  logic        sacq = 1'b0, srel = 1'b0, sack = 1'b0;
  logic        sreq, sgnt, sbusy;
  logic [3:0]  swl, swm;
`endif

  always #5 clk = ~clk;

  async_arb_client #(.SYNC_STAGES(2), .WAIT_W(16)) u_dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .acquire_i (acq),
    .release_i (rel),
    .granted_o (gnt),
    .busy_o    (busy),
    .arb_req_o (req),
    .arb_ack_i (ack)
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    ,
    .wait_last_o (wl),
    .wait_max_o  (wm)
`endif
  );

`ifdef ASYNC_ARB_CLIENT_STATS_EN
  async_arb_client #(.SYNC_STAGES(2), .WAIT_W(4)) u_sat (
    .clock_i     (clk),
    .reset_i     (rst),
    .acquire_i   (sacq),
    .release_i   (srel),
    .granted_o   (sgnt),
    .busy_o      (sbusy),
    .arb_req_o   (sreq),
    .arb_ack_i   (sack),
    .wait_last_o (swl),
    .wait_max_o  (swm)
  );
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event code = kind*1000000 + cycle; kinds: 0 req rise, 1 req fall,
  // 2 gnt rise, 3 gnt fall, 4 busy rise, 5 busy fall.
  int evq[$];
  int wq[$];
  int exp_max = 0;

  task automatic ev(input int kind, input int c);
    evq.push_back(kind * 1000000 + c);
  endtask

  task automatic gnt_ev(input int g, input int e);
    ev(2, g);
    wq.push_back(g - e);
  endtask

  task automatic rep(input int kind);
    if (evq.size() == 0) check("evt_unexpected", kind * 1000000 + cyc, 0);
    else                 check("evt", kind * 1000000 + cyc, evq.pop_front());
  endtask

  logic preq = 1'b0, pgnt = 1'b0, pbusy = 1'b0;
  always @(negedge clk) begin
    if (req && !preq) begin
      rep(0);
      check("req_rise_ack_low", ack, 0);
    end
    if (!req && preq) rep(1);
    if (gnt && !pgnt) begin
      rep(2);
`ifdef ASYNC_ARB_CLIENT_STATS_EN
      if (wq.size() > 0) begin
        int w;
        w = wq.pop_front();
        if (w > exp_max) exp_max = w;
        check("wait_last", wl, w);
        check("wait_max", wm, exp_max);
      end
`endif
    end
    if (!gnt && pgnt) rep(3);
    if (busy && !pbusy) rep(4);
    if (!busy && pbusy) rep(5);
    preq  = req;
    pgnt  = gnt;
    pbusy = busy;
  end

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int c, input logic a, input logic r);
    go(c);
    acq = a;
    rel = r;
    go(c + 1);
    acq = 1'b0;
    rel = 1'b0;
  endtask

  task automatic set_ack(input int c, input logic v);
    go(c);
    ack = v;
  endtask

  int b;

  initial begin
    go(3);
    check("rst_req", req, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
`ifdef ASYNC_ARB_CLIENT_STATS_EN
    check("rst_wait_last", wl, 0);
    check("rst_wait_max", wm, 0);
`endif
    rst = 1'b0;

    // Basic handshake
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); gnt_ev(b + 8, b + 1);
    ev(1, b + 13); ev(3, b + 13); ev(5, b + 18);
    pulse(b, 1, 0);
    set_ack(b + 5, 1);
    pulse(b + 12, 0, 1);
    set_ack(b + 15, 0);
    go(b + 20);

    // Abort: release while still requesting
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); ev(1, b + 9); ev(5, b + 13);
    pulse(b, 1, 0);
    pulse(b + 3, 0, 1);
    set_ack(b + 6, 1);
    set_ack(b + 10, 0);
    go(b + 15);
    check("abort_gnt", gnt, 0);

    // Simultaneous acquire+release while granted
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); gnt_ev(b + 5, b + 1);
    ev(1, b + 8); ev(3, b + 8); ev(5, b + 12);
    ev(0, b + 13); ev(4, b + 13); gnt_ev(b + 18, b + 13);
    ev(1, b + 21); ev(3, b + 21); ev(5, b + 25);
    pulse(b, 1, 0);
    set_ack(b + 2, 1);
    pulse(b + 7, 1, 1);
    set_ack(b + 9, 0);
    set_ack(b + 15, 1);
    pulse(b + 20, 0, 1);
    set_ack(b + 22, 0);
    go(b + 27);

    // Acquire during RELEASE
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); gnt_ev(b + 5, b + 1);
    ev(1, b + 8); ev(3, b + 8); ev(5, b + 13);
    ev(0, b + 14); ev(4, b + 14); gnt_ev(b + 19, b + 14);
    ev(1, b + 22); ev(3, b + 22); ev(5, b + 26);
    pulse(b, 1, 0);
    set_ack(b + 2, 1);
    pulse(b + 7, 0, 1);
    pulse(b + 9, 1, 0);
    set_ack(b + 10, 0);
    set_ack(b + 16, 1);
    pulse(b + 21, 0, 1);
    set_ack(b + 23, 0);
    go(b + 28);

    // Asynchronous reset mid-GRANTED
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); gnt_ev(b + 5, b + 1);
    ev(1, b + 7); ev(3, b + 7); ev(5, b + 7);
    ev(0, b + 11); ev(4, b + 11); gnt_ev(b + 15, b + 11);
    ev(1, b + 18); ev(3, b + 18); ev(5, b + 22);
    pulse(b, 1, 0);
    set_ack(b + 2, 1);
    go(b + 7);
    #2;
    rst = 1'b1;
    ack = 1'b0;
    exp_max = 0;
    #1;
    check("arst_req", req, 0);
    check("arst_gnt", gnt, 0);
    check("arst_busy", busy, 0);
    go(b + 9);
    rst = 1'b0;
    pulse(b + 10, 1, 0);
    set_ack(b + 12, 1);
    pulse(b + 17, 0, 1);
    set_ack(b + 19, 0);
    go(b + 24);

    // Long then short ack delay (wait 10, then 4)
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); gnt_ev(b + 11, b + 1);
    ev(1, b + 13); ev(3, b + 13); ev(5, b + 17);
    pulse(b, 1, 0);
    set_ack(b + 8, 1);
    pulse(b + 12, 0, 1);
    set_ack(b + 14, 0);
    go(b + 19);
    b = cyc + 2;
    ev(0, b + 1); ev(4, b + 1); gnt_ev(b + 5, b + 1);
    ev(1, b + 8); ev(3, b + 8); ev(5, b + 12);
    pulse(b, 1, 0);
    set_ack(b + 2, 1);
    pulse(b + 7, 0, 1);
    set_ack(b + 9, 0);
    go(b + 14);

`ifdef ASYNC_ARB_CLIENT_STATS_EN
    // 4-bit counter saturates on a 40-cycle ack delay
    b = cyc + 2;
    go(b);
    sacq = 1'b1;
    go(b + 1);
    sacq = 1'b0;
    go(b + 40);
    sack = 1'b1;
    go(b + 45);
    check("sat_gnt", sgnt, 1);
    check("sat_wait_last", swl, 15);
    check("sat_wait_max", swm, 15);
`endif

    go(cyc + 3);
    check("evq_empty", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
